// File: rtl/stack_sequencer.sv
// Command-side driver for the 1-bit stack register: opcode handshake, ALU bits, depth tracking, literal serialiser.
// Define STACK_SEQ_DEPTH_CHECK_EN to reject under/overflowing opcodes with an err pulse.
module stack_sequencer #(
    parameter int SIZE  = 8,
    parameter int LIT_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       op_valid_i,
    output logic                       op_ready_o,
    input  logic [3:0]                 op_i,
    input  logic [LIT_W-1:0]           operand_i,
    input  logic                       tos_i,
    input  logic                       nos_i,
    output logic [2:0]                 stack_mode_o,
    output logic                       stack_d_o,
    output logic                       err_o,
    output logic [$clog2(SIZE+1)-1:0]  depth_o
);

    localparam int DW = $clog2(SIZE + 1);
    localparam int CW = (LIT_W > 1) ? $clog2(LIT_W) : 1;

    localparam logic [2:0] STACK_MODE_IDLE  = 3'd0;
    localparam logic [2:0] STACK_MODE_PUSH  = 3'd1;
    localparam logic [2:0] STACK_MODE_POP   = 3'd2;
    localparam logic [2:0] STACK_MODE_SWAP  = 3'd3;
    localparam logic [2:0] STACK_MODE_ROLL  = 3'd4;
    localparam logic [2:0] STACK_MODE_ROLL2 = 3'd5;
    localparam logic [2:0] STACK_MODE_RESET = 3'd6;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LIT} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [CW-1:0]     count_q, count_d;
    logic [LIT_W-1:0]  lit_q, lit_d;
    logic              err_q, err_d;

    logic [2:0]        modeComb;
    logic              dataComb;
    logic              opReady;
    logic              accept;
    logic [1:0]        needDepth;
    logic              pushOp, popOp, clearOp, litOp, reject;

    // The stack applies the command on the same edge, so mode/data are decoded combinationally.
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        count_d   = count_q;
        lit_d     = lit_q;
        err_d     = 1'b0;
        modeComb  = STACK_MODE_IDLE;
        dataComb  = 1'b0;
        needDepth = 2'd0;
        pushOp    = 1'b0;
        popOp     = 1'b0;
        clearOp   = 1'b0;
        litOp     = 1'b0;
        reject    = 1'b0;
        opReady   = (state_q == ST_IDLE);
        accept    = op_valid_i & opReady;

        case (state_q)
            ST_INIT: begin
                modeComb = STACK_MODE_RESET;
                depth_d  = '0;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    case (op_i)
                        4'h1: begin modeComb = STACK_MODE_PUSH; pushOp = 1'b1; end
                        4'h2: begin modeComb = STACK_MODE_PUSH; dataComb = 1'b1; pushOp = 1'b1; end
                        4'h3: begin modeComb = STACK_MODE_POP; needDepth = 2'd1; popOp = 1'b1; end
                        4'h4: begin modeComb = STACK_MODE_SWAP; needDepth = 2'd2; end
                        4'h5: begin modeComb = STACK_MODE_PUSH; dataComb = tos_i; needDepth = 2'd1; pushOp = 1'b1; end
                        4'h6: begin modeComb = STACK_MODE_ROLL; dataComb = ~tos_i; needDepth = 2'd1; end
                        4'h7: begin modeComb = STACK_MODE_ROLL2; dataComb = tos_i & nos_i; needDepth = 2'd2; popOp = 1'b1; end
                        4'h8: begin modeComb = STACK_MODE_ROLL2; dataComb = tos_i | nos_i; needDepth = 2'd2; popOp = 1'b1; end
                        4'h9: begin modeComb = STACK_MODE_ROLL2; dataComb = tos_i ^ nos_i; needDepth = 2'd2; popOp = 1'b1; end
                        4'hA: begin modeComb = STACK_MODE_PUSH; dataComb = nos_i; needDepth = 2'd2; pushOp = 1'b1; end
                        4'hB: begin
                            modeComb = STACK_MODE_PUSH;
                            dataComb = operand_i[LIT_W-1];
                            pushOp   = 1'b1;
                            litOp    = 1'b1;
                        end
                        4'hC: begin modeComb = STACK_MODE_RESET; clearOp = 1'b1; end
                        default: ;
                    endcase

`ifdef STACK_SEQ_DEPTH_CHECK_EN
                    reject = (depth_q < DW'(needDepth))
                           || (pushOp && depth_q == DW'(SIZE))
                           || (litOp && (int'(depth_q) + LIT_W > SIZE));
`else
                    reject = 1'b0;
`endif

                    if (reject) begin
                        modeComb = STACK_MODE_IDLE;
                        dataComb = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        if (pushOp && depth_q != DW'(SIZE))
                            depth_d = depth_q + 1'b1;
                        if (popOp && depth_q != '0)
                            depth_d = depth_q - 1'b1;
                        if (clearOp)
                            depth_d = '0;
                        // MSB already went out on this cycle; count indexes the next bit.
                        if (litOp && LIT_W > 1) begin
                            state_d = ST_LIT;
                            lit_d   = operand_i;
                            count_d = CW'(LIT_W > 1 ? LIT_W - 2 : 0);
                        end
                    end
                end
            end
            ST_LIT: begin
                modeComb = STACK_MODE_PUSH;
                dataComb = lit_q[count_q];
                if (depth_q != DW'(SIZE))
                    depth_d = depth_q + 1'b1;
                if (count_q == '0)
                    state_d = ST_IDLE;
                else
                    count_d = count_q - 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            depth_q <= '0;
            count_q <= '0;
            lit_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            count_q <= count_d;
            lit_q   <= lit_d;
            err_q   <= err_d;
        end
    end

    // Reset must silence the stack immediately, even mid-literal.
    assign stack_mode_o = rst_i ? STACK_MODE_IDLE : modeComb;
    assign stack_d_o    = rst_i ? 1'b0 : dataComb;
    assign op_ready_o   = opReady & ~rst_i;
    assign err_o        = err_q;
    assign depth_o      = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 1-bit stack and an expectation scoreboard.
// Honours STACK_SEQ_DEPTH_CHECK_EN to select the checked or unchecked expectations.
module tb_stack_sequencer;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_PUSH  = 3'd1;
    localparam logic [2:0] M_POP   = 3'd2;
    localparam logic [2:0] M_SWAP  = 3'd3;
    localparam logic [2:0] M_ROLL  = 3'd4;
    localparam logic [2:0] M_ROLL2 = 3'd5;
    localparam logic [2:0] M_RESET = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       opValid;
    logic       opReady;
    logic [3:0] opCode;
    logic [3:0] operandIn;
    logic       tos, nos;
    logic [2:0] stackMode;
    logic       stackD;
    logic       err;
    logic [3:0] depth;
    logic [7:0] stk = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [2:0] mode;
        logic       d;
        bit         chkD;
        logic       rdy;
        logic [3:0] dep;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    stack_sequencer #(.SIZE(8), .LIT_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_valid_i   (opValid),
        .op_ready_o   (opReady),
        .op_i         (opCode),
        .operand_i    (operandIn),
        .tos_i        (tos),
        .nos_i        (nos),
        .stack_mode_o (stackMode),
        .stack_d_o    (stackD),
        .err_o        (err),
        .depth_o      (depth)
    );

    always #5 clk = ~clk;

    assign tos = stk[0];
    assign nos = stk[1];

    // Environment model of the stack register, driven by the sequencer's commands.
    always @(posedge clk) begin
        case (stackMode)
            M_PUSH:  stk <= {stk[6:0], stackD};
            M_POP:   stk <= {1'b0, stk[7:1]};
            M_SWAP:  stk <= {stk[7:2], stk[0], stk[1]};
            M_ROLL:  stk <= {stk[7:1], stackD};
            M_ROLL2: stk <= {1'b0, stk[7:2], stackD};
            M_RESET: stk <= '0;
            default: ;
        endcase
    end

    task automatic checkVal(input string name, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Pops the next expectation and checks the combinational command outputs.
    task automatic checkOutput();
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        cur = sb.pop_front();
        checkVal({cur.tag, "_mode"}, 8'(stackMode), 8'(cur.mode));
        checkVal({cur.tag, "_ready"}, 8'(opReady), 8'(cur.rdy));
        if (cur.chkD)
            checkVal({cur.tag, "_d"}, 8'(stackD), 8'(cur.d));
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [3:0] o,
                                 input logic [3:0] lit, input logic [2:0] m, input logic d,
                                 input bit chkD, input logic rdy, input logic [3:0] dep,
                                 input logic e);
        exp_t x;
        x.tag = tag; x.mode = m; x.d = d; x.chkD = chkD; x.rdy = rdy; x.dep = dep; x.err = e;
        sb.push_back(x);
        opValid   = v;
        opCode    = o;
        operandIn = lit;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        checkVal({tag, "_depth"}, 8'(depth), 8'(cur.dep));
        checkVal({tag, "_err"}, 8'(err), 8'(cur.err));
    endtask

    initial begin
        rst = 1'b1; opValid = 1'b0; opCode = 4'h0; operandIn = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_mode", 8'(stackMode), 8'(M_IDLE));
        checkVal("rst_ready", 8'(opReady), 8'd0);
        checkVal("rst_d", 8'(stackD), 8'd0);
        checkVal("rst_depth", 8'(depth), 8'd0);
        checkVal("rst_err", 8'(err), 8'd0);
        rst = 1'b0;
        applyStimulus("init", 0, 4'h0, 4'h0, M_RESET, 0, 0, 0, 4'd0, 0);
        applyStimulus("idle0", 0, 4'h0, 4'h0, M_IDLE, 0, 1, 1, 4'd0, 0);

        applyStimulus("push1", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 1, 4'd1, 0);
        applyStimulus("push0", 1, 4'h1, 4'h0, M_PUSH, 0, 1, 1, 4'd2, 0);
        applyStimulus("xor", 1, 4'h9, 4'h0, M_ROLL2, 1, 1, 1, 4'd1, 0);
        checkVal("xor_tos", 8'(tos), 8'd1);

        applyStimulus("clr_a", 1, 4'hC, 4'h0, M_RESET, 0, 0, 1, 4'd0, 0);
        applyStimulus("lit_c1", 1, 4'hB, 4'b1011, M_PUSH, 1, 1, 1, 4'd1, 0);
        applyStimulus("lit_c2", 1, 4'h5, 4'h0, M_PUSH, 0, 1, 0, 4'd2, 0);
        applyStimulus("lit_c3", 1, 4'h5, 4'h0, M_PUSH, 1, 1, 0, 4'd3, 0);
        applyStimulus("lit_c4", 1, 4'h5, 4'h0, M_PUSH, 1, 1, 0, 4'd4, 0);
        applyStimulus("lit_c5dup", 1, 4'h5, 4'h0, M_PUSH, 1, 1, 1, 4'd5, 0);

        applyStimulus("clr_b", 1, 4'hC, 4'h0, M_RESET, 0, 0, 1, 4'd0, 0);
        applyStimulus("b_push1", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 1, 4'd1, 0);
        applyStimulus("b_push0", 1, 4'h1, 4'h0, M_PUSH, 0, 1, 1, 4'd2, 0);
        applyStimulus("swap", 1, 4'h4, 4'h0, M_SWAP, 0, 0, 1, 4'd2, 0);
        applyStimulus("over", 1, 4'hA, 4'h0, M_PUSH, 0, 1, 1, 4'd3, 0);
        applyStimulus("not", 1, 4'h6, 4'h0, M_ROLL, 1, 1, 1, 4'd3, 0);
        applyStimulus("and", 1, 4'h7, 4'h0, M_ROLL2, 1, 1, 1, 4'd2, 0);
        applyStimulus("or", 1, 4'h8, 4'h0, M_ROLL2, 1, 1, 1, 4'd1, 0);
        applyStimulus("dup", 1, 4'h5, 4'h0, M_PUSH, 1, 1, 1, 4'd2, 0);
        applyStimulus("pop", 1, 4'h3, 4'h0, M_POP, 0, 0, 1, 4'd1, 0);
        applyStimulus("rsvd", 1, 4'hE, 4'h0, M_IDLE, 0, 1, 1, 4'd1, 0);

        applyStimulus("clr_c", 1, 4'hC, 4'h0, M_RESET, 0, 0, 1, 4'd0, 0);
`ifdef STACK_SEQ_DEPTH_CHECK_EN
        applyStimulus("pop_empty", 1, 4'h3, 4'h0, M_IDLE, 0, 1, 1, 4'd0, 1);
`else
        applyStimulus("pop_empty", 1, 4'h3, 4'h0, M_POP, 0, 0, 1, 4'd0, 0);
`endif
        applyStimulus("after_pop", 0, 4'h0, 4'h0, M_IDLE, 0, 1, 1, 4'd0, 0);

        applyStimulus("clr_d", 1, 4'hC, 4'h0, M_RESET, 0, 0, 1, 4'd0, 0);
        for (int i = 1; i <= 6; i++)
            applyStimulus("fill", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 1, 4'(i), 0);
`ifdef STACK_SEQ_DEPTH_CHECK_EN
        applyStimulus("lit_full", 1, 4'hB, 4'b1010, M_IDLE, 0, 1, 1, 4'd6, 1);
        applyStimulus("fill7", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 1, 4'd7, 0);
        applyStimulus("fill8", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 1, 4'd8, 0);
        applyStimulus("push_full", 1, 4'h2, 4'h0, M_IDLE, 0, 1, 1, 4'd8, 1);
`else
        applyStimulus("lit_full", 1, 4'hB, 4'b1010, M_PUSH, 1, 1, 1, 4'd7, 0);
        applyStimulus("lit_f2", 1, 4'h2, 4'h0, M_PUSH, 0, 1, 0, 4'd8, 0);
        applyStimulus("lit_f3", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 0, 4'd8, 0);
        applyStimulus("lit_f4", 1, 4'h2, 4'h0, M_PUSH, 0, 1, 0, 4'd8, 0);
        applyStimulus("push_full", 1, 4'h2, 4'h0, M_PUSH, 1, 1, 1, 4'd8, 0);
`endif

        applyStimulus("clr_e", 1, 4'hC, 4'h0, M_RESET, 0, 0, 1, 4'd0, 0);
        applyStimulus("lit_r1", 1, 4'hB, 4'b1011, M_PUSH, 1, 1, 1, 4'd1, 0);
        rst = 1'b1;
        opValid = 1'b0;
        #1;
        checkVal("midlit_rst_mode", 8'(stackMode), 8'(M_IDLE));
        checkVal("midlit_rst_ready", 8'(opReady), 8'd0);
        checkVal("midlit_rst_depth", 8'(depth), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("re_init", 0, 4'h0, 4'h0, M_RESET, 0, 0, 0, 4'd0, 0);
        applyStimulus("re_idle", 1, 4'h0, 4'h0, M_IDLE, 0, 1, 1, 4'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
